regfile_write_arbiter: RTL and testbench

Merges two independent write-back sources into the single three-channel write port of the register file (EN / INDEX / DATA, each with VALID/CONSUMED). It sits directly upstream of the register file's write side. Each source gets a 2-entry buffer, round-robin arbitration selects between them, and a registered output stage drives the register file. Write order is preserved per source, and nothing is dropped or duplicated.

---
 rtl/regfile_write_arbiter_pkg.sv | 30 +++
 rtl/regfile_write_arbiter_if.sv | 65 ++++++
 rtl/regfile_write_arbiter_wb_fifo2.sv | 54 +++++
 rtl/regfile_write_arbiter.sv | 120 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: record layout,
// field offsets and the source-select encoding.
package regfile_write_arbiter_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Zero-width fields collapse to a single bit.
  function automatic int unsigned fw(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

  // Record = {data, index, en}, en at bit 0.
  function automatic int unsigned rec_w(
    input int unsigned n,
    input int unsigned width
  );
    return 1 + fw(n) + fw(width);
  endfunction

  localparam int unsigned EN_LSB  = 0;
  localparam int unsigned IDX_LSB = 1;

  function automatic int unsigned data_lsb(input int unsigned n);
    return 1 + fw(n);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Handshake bundles: one write-back source channel and the
// three-channel register-file write port.
interface regfile_write_arbiter_if #(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 5
);
  import regfile_write_arbiter_pkg::*;
  localparam int unsigned DW = fw(width);
  localparam int unsigned IW = fw(n);

  logic          EN;
  logic [IW-1:0] INDEX;
  logic [DW-1:0] DATA;
  logic          VALID;
  logic          CONSUMED;

  modport master (
    output EN, INDEX, DATA, VALID,
    input  CONSUMED
  );
  modport slave (
    input  EN, INDEX, DATA, VALID,
    output CONSUMED
  );
endinterface

interface regfile_write_arbiter_wr_if #(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 5
);
  import regfile_write_arbiter_pkg::*;
  localparam int unsigned DW = fw(width);
  localparam int unsigned IW = fw(n);

  logic          WRITE_EN_WRITE;
  logic [IW-1:0] WRITE_INDEX_WRITE;
  logic [DW-1:0] WRITE_DATA_WRITE;
  logic          WRITE_EN_WRITE_VALID;
  logic          WRITE_INDEX_WRITE_VALID;
  logic          WRITE_DATA_WRITE_VALID;
  logic          WRITE_EN_WRITE_CONSUMED;
  logic          WRITE_INDEX_WRITE_CONSUMED;
  logic          WRITE_DATA_WRITE_CONSUMED;

  modport master (
    output WRITE_EN_WRITE, WRITE_INDEX_WRITE,
    output WRITE_DATA_WRITE,
    output WRITE_EN_WRITE_VALID,
    output WRITE_INDEX_WRITE_VALID,
    output WRITE_DATA_WRITE_VALID,
    input  WRITE_EN_WRITE_CONSUMED,
    input  WRITE_INDEX_WRITE_CONSUMED,
    input  WRITE_DATA_WRITE_CONSUMED
  );
  modport slave (
    input  WRITE_EN_WRITE, WRITE_INDEX_WRITE,
    input  WRITE_DATA_WRITE,
    input  WRITE_EN_WRITE_VALID,
    input  WRITE_INDEX_WRITE_VALID,
    input  WRITE_DATA_WRITE_VALID,
    output WRITE_EN_WRITE_CONSUMED,
    output WRITE_INDEX_WRITE_CONSUMED,
    output WRITE_DATA_WRITE_CONSUMED
  );
endinterface

// File: rtl/regfile_write_arbiter_wb_fifo2.sv
// Two-entry write-back record FIFO. Ports: enq_* (valid/consumed
// + record), deq_* (head valid, take strobe, head record), count_o.
module wb_fifo2 #(
  parameter int unsigned W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enq_valid_i,
  output logic         enq_consumed_o,
  input  logic [W-1:0] enq_rec_i,
  output logic         deq_valid_o,
  input  logic         deq_take_i,
  output logic [W-1:0] deq_rec_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] e0_q, e1_q;
  logic         rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         enq, deq, wr_sel;

  // Acceptance depends only on occupancy, never on a same-cycle dequeue.
  assign enq            = enq_valid_i && (cnt_q != 2'd2);
  assign deq            = deq_take_i && (cnt_q != 2'd0);
  assign enq_consumed_o = enq;
  assign deq_valid_o    = (cnt_q != 2'd0);
  assign deq_rec_o      = rd_q ? e1_q : e0_q;
  assign count_o        = cnt_q;
  // Write slot is the one after the occupied entries.
  assign wr_sel         = rd_q ^ cnt_q[0];

  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    if (enq && !deq) cnt_d = cnt_q + 2'd1;
    if (!enq && deq) cnt_d = cnt_q - 2'd1;
    if (deq) rd_d = ~rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      if (enq && !wr_sel) e0_q <= enq_rec_i;
      if (enq &&  wr_sel) e1_q <= enq_rec_i;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges write-back sources A and B into the register-file write port.
// Ports: CLK, RST, A/B source channels, W write port, BUSY.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned n     = 5
) (
  input  logic                        CLK,
  input  logic                        RST,
  regfile_write_arbiter_if.slave      A,
  regfile_write_arbiter_if.slave      B,
  regfile_write_arbiter_wr_if.master  W,
  output logic                        BUSY
);

  localparam int unsigned DW = fw(width);
  localparam int unsigned IW = fw(n);
  localparam int unsigned RW = rec_w(n, width);
  localparam int unsigned DL = data_lsb(n);

  logic [DW-1:0] a_data, b_data;
  logic [IW-1:0] a_idx, b_idx;
  logic [RW-1:0] a_rec, b_rec, a_head, b_head;
  logic          a_hv, b_hv, a_deq, b_deq;
  logic [1:0]    a_cnt, b_cnt;

  logic          out_valid_q, out_valid_d;
  logic [RW-1:0] out_rec_q, out_rec_d;
  src_e          last_q, last_d, grant;
  logic          fire, load;

  // Collapsed fields are stored as 0.
  assign a_data = (width == 0) ? '0 : A.DATA;
  assign b_data = (width == 0) ? '0 : B.DATA;
  assign a_idx  = (n == 0) ? '0 : A.INDEX;
  assign b_idx  = (n == 0) ? '0 : B.INDEX;
  assign a_rec  = {a_data, a_idx, A.EN};
  assign b_rec  = {b_data, b_idx, B.EN};

  wb_fifo2 #(.W(RW)) u_fifo_a (
    .clk            (CLK),
    .rst            (RST),
    .enq_valid_i    (A.VALID),
    .enq_consumed_o (A.CONSUMED),
    .enq_rec_i      (a_rec),
    .deq_valid_o    (a_hv),
    .deq_take_i     (a_deq),
    .deq_rec_o      (a_head),
    .count_o        (a_cnt)
  );

  wb_fifo2 #(.W(RW)) u_fifo_b (
    .clk            (CLK),
    .rst            (RST),
    .enq_valid_i    (B.VALID),
    .enq_consumed_o (B.CONSUMED),
    .enq_rec_i      (b_rec),
    .deq_valid_o    (b_hv),
    .deq_take_i     (b_deq),
    .deq_rec_o      (b_head),
    .count_o        (b_cnt)
  );

  // A transfer needs all three channels to agree.
  assign fire = out_valid_q
             && W.WRITE_EN_WRITE_CONSUMED
             && W.WRITE_INDEX_WRITE_CONSUMED
             && W.WRITE_DATA_WRITE_CONSUMED;

  always_comb begin
    grant = SRC_A;
    unique case (1'b1)
      (a_hv && !b_hv): grant = SRC_A;
      (!a_hv && b_hv): grant = SRC_B;
      default:
        grant = (last_q == SRC_A) ? SRC_B : SRC_A;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_rec_d   = out_rec_q;
    last_d      = last_q;
    load  = (!out_valid_q || fire) && (a_hv || b_hv);
    a_deq = load && (grant == SRC_A);
    b_deq = load && (grant == SRC_B);
    if (load) begin
      out_valid_d = 1'b1;
      out_rec_d   = (grant == SRC_A) ? a_head : b_head;
      last_d      = grant;
    end else if (fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_rec_q   <= '0;
      last_q      <= SRC_B;
    end else begin
      out_valid_q <= out_valid_d;
      out_rec_q   <= out_rec_d;
      last_q      <= last_d;
    end
  end

  assign W.WRITE_EN_WRITE          = out_rec_q[EN_LSB];
  assign W.WRITE_INDEX_WRITE       = out_rec_q[IDX_LSB +: IW];
  assign W.WRITE_DATA_WRITE        = out_rec_q[DL +: DW];
  assign W.WRITE_EN_WRITE_VALID    = out_valid_q;
  assign W.WRITE_INDEX_WRITE_VALID = out_valid_q;
  assign W.WRITE_DATA_WRITE_VALID  = out_valid_q;

  assign BUSY = out_valid_q
             || (a_cnt != 2'd0)
             || (b_cnt != 2'd0);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios
// plus a randomized run against a per-source ordering scoreboard.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  idx;
    logic [31:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.width(32), .n(5)) a_if ();
  regfile_write_arbiter_if #(.width(32), .n(5)) b_if ();
  regfile_write_arbiter_wr_if #(.width(32), .n(5)) w_if ();

  regfile_write_arbiter #(.width(32), .n(5)) dut (
    .CLK  (clk),
    .RST  (rst),
    .A    (a_if),
    .B    (b_if),
    .W    (w_if),
    .BUSY (busy)
  );

  int tests_run = 0;
  int fails     = 0;

  rec_t a_q[$], b_q[$], acc_a[$], acc_b[$], out_q[$];
  int   out_cyc[$];
  int   cyc, outstanding, busy_err, cap_err;
  logic [2:0] cons3 = 3'b111;
  bit   gate_a = 1'b1, gate_b = 1'b1;

  function automatic rec_t cur_out();
    return {w_if.WRITE_EN_WRITE, w_if.WRITE_INDEX_WRITE,
            w_if.WRITE_DATA_WRITE};
  endfunction

  function automatic logic [2:0] valids();
    return {w_if.WRITE_EN_WRITE_VALID,
            w_if.WRITE_INDEX_WRITE_VALID,
            w_if.WRITE_DATA_WRITE_VALID};
  endfunction

  // Drives sources from a_q/b_q, records transfers; model tracks
  // how many accepted records have not yet left the output.
  task automatic stream(input int ncyc);
    bit af, bf, of;
    rec_t ra, rb;
    for (int i = 0; i < ncyc; i++) begin
      ra = (a_q.size() != 0) ? a_q[0] : '0;
      rb = (b_q.size() != 0) ? b_q[0] : '0;
      a_if.VALID = gate_a && (a_q.size() != 0);
      a_if.EN = ra.en; a_if.INDEX = ra.idx; a_if.DATA = ra.data;
      b_if.VALID = gate_b && (b_q.size() != 0);
      b_if.EN = rb.en; b_if.INDEX = rb.idx; b_if.DATA = rb.data;
      w_if.WRITE_EN_WRITE_CONSUMED    = cons3[0];
      w_if.WRITE_INDEX_WRITE_CONSUMED = cons3[1];
      w_if.WRITE_DATA_WRITE_CONSUMED  = cons3[2];
      #1;
      if (busy !== (outstanding != 0)) busy_err++;
      if (outstanding > 5) cap_err++;
      af = a_if.VALID && a_if.CONSUMED;
      bf = b_if.VALID && b_if.CONSUMED;
      of = w_if.WRITE_EN_WRITE_VALID && (&cons3);
      if (of) begin
        out_q.push_back(cur_out());
        out_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (af) begin acc_a.push_back(a_q.pop_front()); outstanding++; end
      if (bf) begin acc_b.push_back(b_q.pop_front()); outstanding++; end
      if (of) outstanding--;
      cyc++;
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_if.VALID = 1'b0;
    b_if.VALID = 1'b0;
    cons3 = 3'b111; gate_a = 1'b1; gate_b = 1'b1;
    a_q.delete(); b_q.delete(); acc_a.delete(); acc_b.delete();
    out_q.delete(); out_cyc.delete();
    outstanding = 0; cyc = 0; busy_err = 0; cap_err = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.VALID = 1'b1; a_if.EN = 1'b1; a_if.INDEX = 5'd1; a_if.DATA = 32'h1;
    b_if.VALID = 1'b0; b_if.EN = 1'b0; b_if.INDEX = 5'd0; b_if.DATA = 32'h0;
    w_if.WRITE_EN_WRITE_CONSUMED    = 1'b0;
    w_if.WRITE_INDEX_WRITE_CONSUMED = 1'b0;
    w_if.WRITE_DATA_WRITE_CONSUMED  = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (valids() !== 3'b000) begin
      fails++; $display("FAIL reset_valid got %b want 000", valids());
    end
    tests_run++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %b want 0", busy);
    end
    tests_run++;
    if (cur_out() !== '0) begin
      fails++; $display("FAIL reset_rec got %h want 0", cur_out());
    end
    tests_run++;
    if (a_if.CONSUMED !== 1'b1 || b_if.CONSUMED !== 1'b0) begin
      fails++;
      $display("FAIL reset_consumed got A=%b B=%b want A=1 B=0",
               a_if.CONSUMED, b_if.CONSUMED);
    end
    do_reset();
  endtask

  task automatic test_single();
    rec_t exp;
    do_reset();
    exp = {1'b1, 5'd3, 32'hDEADBEEF};
    a_q.push_back(exp);
    stream(1);
    tests_run++;
    if (acc_a.size() != 1 || valids() !== 3'b000) begin
      fails++;
      $display("FAIL single_accept got acc=%0d v=%b want 1 000",
               acc_a.size(), valids());
    end
    stream(1);
    tests_run++;
    if (valids() !== 3'b111 || cur_out() !== exp) begin
      fails++;
      $display("FAIL single_out got v=%b rec=%h want 111 %h",
               valids(), cur_out(), exp);
    end
    stream(1);
    tests_run++;
    if (busy !== 1'b0 || valids() !== 3'b000 || out_q.size() != 1) begin
      fails++;
      $display("FAIL single_drain got busy=%b v=%b n=%0d want 0 000 1",
               busy, valids(), out_q.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_idx[8] = '{1, 17, 2, 18, 3, 19, 4, 20};
    bit ok;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      a_q.push_back({1'b1, 5'(i), 32'hA000_0000 + 32'(i)});
      b_q.push_back({1'b1, 5'(16 + i), 32'hB000_0000 + 32'(i)});
    end
    stream(14);
    tests_run++;
    if (out_q.size() != 8) begin
      fails++; $display("FAIL rr_count got %0d want 8", out_q.size());
    end else begin
      ok = 1'b1;
      foreach (exp_idx[i]) if (out_q[i].idx != 5'(exp_idx[i])) ok = 1'b0;
      tests_run++;
      if (!ok) begin
        fails++;
        $display("FAIL rr_order got %0d,%0d,%0d,%0d want 1,17,2,18",
                 out_q[0].idx, out_q[1].idx, out_q[2].idx, out_q[3].idx);
      end
      ok = 1'b1;
      foreach (out_cyc[i]) if (out_cyc[i] != out_cyc[0] + i) ok = 1'b0;
      tests_run++;
      if (!ok || out_cyc[0] != 2) begin
        fails++;
        $display("FAIL rr_gaps got first=%0d last=%0d want 2 9",
                 out_cyc[0], out_cyc[7]);
      end
    end
    tests_run++;
    if (busy_err != 0) begin
      fails++; $display("FAIL rr_busy got %0d errs want 0", busy_err);
    end
  endtask

  task automatic test_backpressure();
    rec_t snap, buffered[$];
    bit stable, ok, found;
    int ai, bi;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      a_q.push_back({1'b1, 5'(i), 32'hA100_0000 + 32'(i)});
      b_q.push_back({1'b1, 5'(16 + i), 32'hB100_0000 + 32'(i)});
    end
    cons3 = 3'b000;
    stream(2);
    snap = cur_out();
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      stream(1);
      if (cur_out() !== snap || valids() !== 3'b111) stable = 1'b0;
    end
    tests_run++;
    if (acc_a.size() + acc_b.size() != 5) begin
      fails++;
      $display("FAIL bp_capacity got %0d want 5",
               acc_a.size() + acc_b.size());
    end
    tests_run++;
    if (a_if.CONSUMED !== 1'b0 || b_if.CONSUMED !== 1'b0) begin
      fails++;
      $display("FAIL bp_consumed got A=%b B=%b want 0 0",
               a_if.CONSUMED, b_if.CONSUMED);
    end
    tests_run++;
    if (!stable || snap.idx !== 5'd1) begin
      fails++;
      $display("FAIL bp_stable got stable=%b idx=%0d want 1 1",
               stable, snap.idx);
    end
    foreach (acc_a[i]) buffered.push_back(acc_a[i]);
    foreach (acc_b[i]) buffered.push_back(acc_b[i]);
    cons3 = 3'b111;
    stream(25);
    tests_run++;
    if (out_q.size() != 12) begin
      fails++; $display("FAIL bp_drain got %0d want 12", out_q.size());
    end else begin
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
        found = 1'b0;
        foreach (buffered[j]) if (buffered[j] === out_q[i]) found = 1'b1;
        if (!found) ok = 1'b0;
      end
      tests_run++;
      if (!ok) begin
        fails++;
        $display("FAIL bp_first5 got idx0=%0d want buffered record",
                 out_q[0].idx);
      end
      ok = 1'b1; ai = 0; bi = 0;
      foreach (out_q[i]) begin
        if (out_q[i].idx[4]) begin
          if (out_q[i] !== acc_b[bi]) ok = 1'b0;
          bi++;
        end else begin
          if (out_q[i] !== acc_a[ai]) ok = 1'b0;
          ai++;
        end
      end
      tests_run++;
      if (!ok || ai != 6 || bi != 6) begin
        fails++;
        $display("FAIL bp_order got a=%0d b=%0d want 6 6 in order",
                 ai, bi);
      end
    end
    tests_run++;
    if (busy_err != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_busy got errs=%0d busy=%b want 0 0",
               busy_err, busy);
    end
  endtask

  task automatic test_partial_consumed();
    rec_t exp;
    do_reset();
    exp = {1'b1, 5'd12, 32'h0C0C_0C0C};
    a_q.push_back(exp);
    cons3 = 3'b101;
    stream(5);
    tests_run++;
    if (out_q.size() != 0 || valids() !== 3'b111 || cur_out() !== exp)
    begin
      fails++;
      $display("FAIL partial_hold got n=%0d v=%b rec=%h want 0 111 %h",
               out_q.size(), valids(), cur_out(), exp);
    end
    cons3 = 3'b111;
    stream(1);
    tests_run++;
    if (out_q.size() != 1 || valids() !== 3'b000) begin
      fails++;
      $display("FAIL partial_release got n=%0d v=%b want 1 000",
               out_q.size(), valids());
    end
  endtask

  task automatic test_reset_midstream();
    rec_t exp;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      a_q.push_back({1'b1, 5'(i), 32'hA200_0000 + 32'(i)});
      b_q.push_back({1'b1, 5'(16 + i), 32'hB200_0000 + 32'(i)});
    end
    cons3 = 3'b000;
    stream(2);
    tests_run++;
    if (outstanding != 4 || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_prefill got n=%0d busy=%b want 4 1",
               outstanding, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (valids() !== 3'b000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_async got v=%b busy=%b want 000 0",
               valids(), busy);
    end
    a_if.VALID = 1'b0;
    b_if.VALID = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    a_q.delete(); b_q.delete(); acc_a.delete(); acc_b.delete();
    out_q.delete(); out_cyc.delete();
    outstanding = 0; cyc = 0; busy_err = 0;
    exp = {1'b1, 5'd9, 32'h1234_5678};
    a_q.push_back(exp);
    cons3 = 3'b111;
    stream(5);
    tests_run++;
    if (out_q.size() != 1 || out_q[0] !== exp) begin
      fails++;
      $display("FAIL mid_fresh got n=%0d rec=%h want 1 %h",
               out_q.size(), (out_q.size() != 0) ? out_q[0] : '0, exp);
    end
  endtask

  task automatic test_en0();
    rec_t exp;
    do_reset();
    exp = {1'b0, 5'd7, 32'h0000_0055};
    b_q.push_back(exp);
    cons3 = 3'b000;
    stream(3);
    tests_run++;
    if (valids() !== 3'b111 || cur_out() !== exp) begin
      fails++;
      $display("FAIL en0_fwd got v=%b rec=%h want 111 %h",
               valids(), cur_out(), exp);
    end
    cons3 = 3'b111;
    stream(2);
    tests_run++;
    if (out_q.size() != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL en0_drain got n=%0d busy=%b want 1 0",
               out_q.size(), busy);
    end
  endtask

  task automatic test_random();
    bit done, ok;
    int ai, bi;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      a_q.push_back({1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     1'b0, 15'($urandom), 16'(i)});
      b_q.push_back({1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     1'b1, 15'($urandom), 16'(i)});
    end
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      gate_a = ($urandom_range(0, 3) != 0);
      gate_b = ($urandom_range(0, 3) != 0);
      cons3 = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
      stream(1);
      done = (a_q.size() == 0) && (b_q.size() == 0) && (outstanding == 0);
    end
    cons3 = 3'b111; gate_a = 1'b1; gate_b = 1'b1;
    tests_run++;
    if (!done) begin
      fails++;
      $display("FAIL rand_timeout got left=%0d want 0",
               a_q.size() + b_q.size() + outstanding);
    end
    ok = 1'b1; ai = 0; bi = 0;
    foreach (out_q[i]) begin
      if (out_q[i].data[31]) begin
        if (bi >= acc_b.size() || out_q[i] !== acc_b[bi]) ok = 1'b0;
        bi++;
      end else begin
        if (ai >= acc_a.size() || out_q[i] !== acc_a[ai]) ok = 1'b0;
        ai++;
      end
    end
    tests_run++;
    if (!ok || ai != 40 || bi != 40) begin
      fails++;
      $display("FAIL rand_order got a=%0d b=%0d ok=%b want 40 40 1",
               ai, bi, ok);
    end
    tests_run++;
    if (busy_err != 0 || cap_err != 0) begin
      fails++;
      $display("FAIL rand_busy got busy_errs=%0d cap_errs=%0d want 0 0",
               busy_err, cap_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_partial_consumed();
    test_reset_midstream();
    test_en0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
